// File: rtl/apb_master_port_pkg.sv
// Shared definitions for the APB master port: state encoding, default bus
// geometry and the one-hot select check.
package apb_master_port_pkg;

  localparam int APB_WIDTH  = 32;
  localparam int APB_SLAVES = 3;
  localparam int SEL_MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // Selects narrower than SEL_MAX_W are zero-extended by the caller.
  function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - SEL_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path mux: picks Prdata/Pready/Pslverr of the slave named by a
// one-hot select using an AND-OR tree.
module apb_slave_mux
  import apb_master_port_pkg::*;
#(
  parameter int WIDTH  = APB_WIDTH,
  parameter int SLAVES = APB_SLAVES
) (
  input  logic [SLAVES-1:0]       sel,
  input  logic [SLAVES*WIDTH-1:0] prdata,
  input  logic [SLAVES-1:0]       pready,
  input  logic [SLAVES-1:0]       pslverr,
  output logic [WIDTH-1:0]        rdata,
  output logic                    ready,
  output logic                    slverr
);

  always_comb begin
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      rdata  = rdata | (prdata[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
      ready  = ready | (pready[i] & sel[i]);
      slverr = slverr | (pslverr[i] & sel[i]);
    end
  end

endmodule

// File: rtl/apb_master_port.sv
// Sequenced APB master for the AHB-to-APB bridge: one request at a time,
// registered SETUP/ACCESS phases, wait-state timeout and illegal-select reject.
module apb_master_port
  import apb_master_port_pkg::*;
#(
  parameter int WIDTH   = APB_WIDTH,
  parameter int SLAVES  = APB_SLAVES,
  parameter int TIMEOUT = 16
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WIDTH-1:0]        req_addr,
  input  logic                    req_write,
  input  logic [WIDTH-1:0]        req_wdata,
  input  logic [SLAVES-1:0]       req_sel,
  output logic                    rsp_valid,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [WIDTH-1:0]        Paddr,
  output logic                    Pwrite,
  output logic                    Penable,
  output logic [WIDTH-1:0]        Pwdata,
  output logic [SLAVES-1:0]       Pselx,
  input  logic [SLAVES*WIDTH-1:0] Prdata,
  input  logic [SLAVES-1:0]       Pready,
  input  logic [SLAVES-1:0]       Pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [WIDTH-1:0]  sel_rdata;
  logic              sel_ready;
  logic              sel_slverr;
  logic              req_fire;
  logic              req_legal;

  // Pselx doubles as the latched select: it holds the request's sel
  // for the whole SETUP/ACCESS span, which is the only time it is consulted.
  apb_slave_mux #(
    .WIDTH  (WIDTH),
    .SLAVES (SLAVES)
  ) u_slave_mux (
    .sel     (Pselx),
    .prdata  (Prdata),
    .pready  (Pready),
    .pslverr (Pslverr),
    .rdata   (sel_rdata),
    .ready   (sel_ready),
    .slverr  (sel_slverr)
  );

  assign req_fire  = req_valid && req_ready;
  assign req_legal = is_onehot(SEL_MAX_W'(req_sel));

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      Paddr       <= '0;
      Pwrite      <= 1'b0;
      Penable     <= 1'b0;
      Pwdata      <= '0;
      Pselx       <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_fire) begin
            req_ready <= 1'b0;
            if (req_legal) begin
              Paddr   <= req_addr;
              Pwrite  <= req_write;
              Pwdata  <= req_wdata;
              Pselx   <= req_sel;
              Penable <= 1'b0;
              state   <= SETUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          Penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A ready in the last counted cycle completes rather than times out.
          if (sel_ready) begin
            Pselx     <= '0;
            Penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_slverr;
            rsp_rdata <= (!Pwrite && !sel_slverr) ? sel_rdata : '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
            Pselx       <= '0;
            Penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            req_ready   <= 1'b1;
            state       <= IDLE;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          Pselx     <= '0;
          Penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_port.sv
// Bench for apb_master_port: directed vector table, reset sequences and
// randomized transfers checked against a cycle-level transfer model.
module tb_apb_master_port;

  localparam int WIDTH   = 32;
  localparam int SLAVES  = 3;
  localparam int TIMEOUT = 4;

  logic                    Hclk = 1'b0;
  logic                    Hresetn = 1'b0;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic [WIDTH-1:0]        req_addr = '0;
  logic                    req_write = 1'b0;
  logic [WIDTH-1:0]        req_wdata = '0;
  logic [SLAVES-1:0]       req_sel = '0;
  logic                    rsp_valid;
  logic [WIDTH-1:0]        rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;
  logic [WIDTH-1:0]        Paddr;
  logic                    Pwrite;
  logic                    Penable;
  logic [WIDTH-1:0]        Pwdata;
  logic [SLAVES-1:0]       Pselx;
  logic [SLAVES*WIDTH-1:0] Prdata = '0;
  logic [SLAVES-1:0]       Pready = '0;
  logic [SLAVES-1:0]       Pslverr = '0;

  always #5 Hclk = ~Hclk;

  apb_master_port #(
    .WIDTH   (WIDTH),
    .SLAVES  (SLAVES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_sel     (req_sel),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .Paddr       (Paddr),
    .Pwrite      (Pwrite),
    .Penable     (Penable),
    .Pwdata      (Pwdata),
    .Pselx       (Pselx),
    .Prdata      (Prdata),
    .Pready      (Pready),
    .Pslverr     (Pslverr)
  );

  typedef struct {
    logic [WIDTH-1:0]  addr;
    logic              write;
    logic [WIDTH-1:0]  wdata;
    logic [SLAVES-1:0] sel;
    int                waits;   // cycles the selected slave holds Pready low in ACCESS
    logic              err;
    logic [WIDTH-1:0]  rd;
    int                lat;     // cycles from accept to rsp_valid
    logic              e_err;
    logic              e_to;
    logic [WIDTH-1:0]  e_rdata;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  // Reference: outcome of a transfer derived from the protocol rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic timed;
    r = v;
    if ($countones(v.sel) != 1) begin
      r.lat = 1; r.e_err = 1'b1; r.e_to = 1'b0; r.e_rdata = '0;
    end else begin
      timed     = (v.waits >= TIMEOUT);
      r.lat     = 2 + (timed ? TIMEOUT : v.waits + 1);
      r.e_to    = timed;
      r.e_err   = timed | v.err;
      r.e_rdata = (!v.write && !r.e_err) ? v.rd : '0;
    end
    return r;
  endfunction

  task automatic drive_slaves(input vec_t v, input int c, input logic legal);
    for (int i = 0; i < SLAVES; i++) begin
      if (legal && v.sel[i]) begin
        Pready[i]                 = (c >= 2 + v.waits);
        Pslverr[i]                = v.err;
        Prdata[i*WIDTH +: WIDTH]  = v.rd;
      end else begin
        Pready[i]                 = 1'($urandom);
        Pslverr[i]                = 1'($urandom);
        Prdata[i*WIDTH +: WIDTH]  = $urandom;
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    vec_t none;
    none = '{default: '0};
    req_valid = 1'b0;
    drive_slaves(none, 0, 1'b0);
    step();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'(0));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(0));
    chk({tag, ".pselx"}, 32'(Pselx), 32'(0));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(1));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic legal;
    legal = ($countones(v.sel) == 1);
    chk({tag, ".ready_in"}, 32'(req_ready), 32'(1));
    for (int c = 0; c < v.lat; c++) begin
      req_valid = (c == 0);
      if (c == 0) begin
        req_addr = v.addr; req_write = v.write; req_wdata = v.wdata; req_sel = v.sel;
      end else begin
        req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
        req_sel = 3'($urandom);
      end
      drive_slaves(v, c, legal);
      step();
      if (c + 1 < v.lat) begin
        chk($sformatf("%s.c%0d.rsp_valid", tag, c + 1), 32'(rsp_valid), 32'(0));
        chk($sformatf("%s.c%0d.pselx", tag, c + 1), 32'(Pselx), 32'(v.sel));
        chk($sformatf("%s.c%0d.paddr", tag, c + 1), Paddr, v.addr);
        chk($sformatf("%s.c%0d.pwrite", tag, c + 1), 32'(Pwrite), 32'(v.write));
        chk($sformatf("%s.c%0d.pwdata", tag, c + 1), Pwdata, v.wdata);
        chk($sformatf("%s.c%0d.penable", tag, c + 1), 32'(Penable), 32'(c + 1 >= 2));
        chk($sformatf("%s.c%0d.req_ready", tag, c + 1), 32'(req_ready), 32'(0));
      end else begin
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1));
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.e_err));
        chk({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(v.e_to));
        chk({tag, ".rsp_rdata"}, rsp_rdata, v.e_rdata);
        chk({tag, ".pselx_end"}, 32'(Pselx), 32'(0));
        chk({tag, ".penable_end"}, 32'(Penable), 32'(0));
        chk({tag, ".req_ready_end"}, 32'(req_ready), 32'(legal));
      end
    end
    req_valid = 1'b0;
    if (!legal) idle_cycle({tag, ".post"});
  endtask

  vec_t tbl[11];
  vec_t v;

  initial begin
    // addr, write, wdata, sel, waits, err, rd, lat, e_err, e_to, e_rdata
    tbl[0]  = '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3'b001, 0,  1'b0, 32'h1111_1111, 3, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{32'h8000_0020, 1'b0, 32'h0000_0000, 3'b100, 2,  1'b0, 32'h1234_5678, 5, 1'b0, 1'b0, 32'h1234_5678};
    tbl[2]  = '{32'h8000_0030, 1'b0, 32'h0000_0000, 3'b010, 0,  1'b1, 32'hAAAA_5555, 3, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{32'h8000_0040, 1'b0, 32'h0000_0000, 3'b001, 20, 1'b0, 32'h2222_2222, 6, 1'b1, 1'b1, 32'h0};
    tbl[4]  = '{32'h8000_0050, 1'b1, 32'hCAFE_F00D, 3'b100, 1,  1'b0, 32'h3333_3333, 4, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{32'h8000_0060, 1'b1, 32'h0000_0001, 3'b011, 0,  1'b0, 32'h0,         1, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{32'h8000_0070, 1'b0, 32'h0000_0002, 3'b000, 0,  1'b0, 32'h0,         1, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{32'h8000_0080, 1'b0, 32'h0000_0000, 3'b010, 3,  1'b0, 32'h0BAD_F00D, 6, 1'b0, 1'b0, 32'h0BAD_F00D};
    tbl[8]  = '{32'h8000_0090, 1'b0, 32'h0000_0000, 3'b100, 4,  1'b0, 32'h4444_4444, 6, 1'b1, 1'b1, 32'h0};
    tbl[9]  = '{32'h8000_00A0, 1'b1, 32'h5555_AAAA, 3'b010, 1,  1'b1, 32'h6666_6666, 4, 1'b1, 1'b0, 32'h0};
    tbl[10] = '{32'h8000_00B0, 1'b0, 32'h0000_0000, 3'b111, 0,  1'b0, 32'h0,         1, 1'b1, 1'b0, 32'h0};

    // Reset state, with a request presented that must be ignored.
    req_valid = 1'b1; req_sel = 3'b001; req_addr = 32'h1234;
    step(); step();
    chk("rst.req_ready", 32'(req_ready), 32'(1));
    chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst.pselx", 32'(Pselx), 32'(0));
    chk("rst.penable", 32'(Penable), 32'(0));
    chk("rst.paddr", Paddr, 32'(0));
    chk("rst.rsp_err", 32'(rsp_err), 32'(0));
    req_valid = 1'b0;
    Hresetn = 1'b1;
    step();
    chk("rel.req_ready", 32'(req_ready), 32'(1));
    chk("rel.pselx", 32'(Pselx), 32'(0));
    chk("rel.rsp_valid", 32'(rsp_valid), 32'(0));

    // Directed vectors applied back to back.
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    idle_cycle("gap");

    // Reset during an ACCESS wait state.
    req_valid = 1'b1; req_addr = 32'h8000_0100; req_write = 1'b0; req_sel = 3'b001;
    Pready = '0; Pslverr = '0;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("mid.penable", 32'(Penable), 32'(1));
    chk("mid.pselx", 32'(Pselx), 32'(1));
    Hresetn = 1'b0;
    step();
    chk("mid.rst.pselx", 32'(Pselx), 32'(0));
    chk("mid.rst.penable", 32'(Penable), 32'(0));
    chk("mid.rst.rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid.rst.paddr", Paddr, 32'(0));
    Hresetn = 1'b1;
    step();
    chk("mid.rel.req_ready", 32'(req_ready), 32'(1));
    chk("mid.rel.rsp_valid", 32'(rsp_valid), 32'(0));
    idle_cycle("mid.idle");
    run_vec(tbl[1], "mid.after");

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++) begin
      v = '{default: '0};
      v.addr  = $urandom;
      v.write = 1'($urandom);
      v.wdata = $urandom;
      v.sel   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
      v.waits = $urandom_range(0, 6);
      v.err   = ($urandom_range(0, 3) == 0);
      v.rd    = $urandom;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd%0d.gap", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_port.md
Name: apb_master_port

Overview:
- Parametrised APB master port for the AHB-to-APB bridge. It replaces the combinational APB pass-through with a sequenced master.
- Accepts one transfer request at a time from the bridge FSM over a valid/ready handshake. Drives the APB SETUP and ACCESS phases from registers.
- Honours per-slave Pready wait states and Pslverr. Returns a one-cycle response (read data and error) to the bridge.
- Adds a wait-state timeout and illegal-select rejection. Sits between the bridge FSM and the SLAVES APB peripherals.

Parameters:
- WIDTH, 32: address and data width.
- SLAVES, 3: number of APB slaves; sets the width of the one-hot select.
- TIMEOUT, 16: maximum number of ACCESS cycles without Pready; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1): width of the wait counter (derived; not overridden).

Ports:
- Hclk  in  1  clock.
- Hresetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  bridge presents a transfer.
- req_ready  out  1  port can accept a transfer.
- req_addr  in  WIDTH  transfer address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  WIDTH  write data.
- req_sel  in  SLAVES  one-hot slave select.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, timeout or illegal select.
- rsp_timeout  out  1  the error was caused by timeout.
- Paddr  out  WIDTH  APB address.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB enable.
- Pwdata  out  WIDTH  APB write data.
- Pselx  out  SLAVES  APB one-hot select.
- Prdata  in  SLAVES*WIDTH  per-slave read data; slave i occupies bits [i*WIDTH +: WIDTH].
- Pready  in  SLAVES  per-slave ready.
- Pslverr  in  SLAVES  per-slave error.

Behaviour:
- Clock and reset: one clock, Hclk. Hresetn is synchronous and active-low; it is sampled only on the rising edge of Hclk.
- Registered outputs: all outputs are registered. During reset and on the first edge after reset: every output is 0, except req_ready = 1. State = IDLE, wait counter = 0.

State machine:
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready with exactly one bit set in req_sel: latch addr, write, wdata and sel. Drive Paddr, Pwrite, Pwdata and Pselx = sel with Penable = 0 on the next edge. Go to SETUP.
  - With zero or multiple bits set in req_sel: no APB activity. Next cycle rsp_valid = 1, rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0. Stay in IDLE; req_ready drops for that one cycle.
- SETUP
  - Lasts exactly one cycle; req_ready = 0.
  - Next edge: Penable = 1. Go to ACCESS; wait counter = 0.
- ACCESS
  - Paddr, Pwrite, Pwdata and Pselx are held stable. Only the selected slave's Prdata, Pready and Pslverr are observed.
  - Pready[sel] = 1: next edge Pselx = 0, Penable = 0, rsp_valid = 1, rsp_err = Pslverr[sel]. rsp_rdata = Prdata slice of sel when read and no error, else 0. Go to IDLE.
  - Pready[sel] = 0 and TIMEOUT ≠ 0 and counter = TIMEOUT-1: abort. Same deassertion and response as a completion, with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Go to IDLE.
  - Otherwise: counter increments and the port stays in ACCESS.

Timing and handshake:
- Minimum latency: request accept -> rsp_valid is 3 cycles (0 wait states). Each wait state adds 1 cycle.
- Back-to-back transfers: the next request is accepted no earlier than the rsp_valid cycle, since IDLE is re-entered then. Pselx is deasserted for at least 1 cycle between transfers.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata, rsp_err and rsp_timeout are valid only while rsp_valid = 1 and are cleared to 0 otherwise.
- Pwdata retains the latched request value on reads; it is not meaningful on reads.
- Pready and Pslverr are ignored outside ACCESS and on unselected slaves.

Reset and boundary cases:
- Reset mid-transfer: on the next edge all APB outputs are 0 and no response is issued.
- Pready in the same cycle the timeout would fire: completion wins, so rsp_timeout = 0.

Decomposition:
- Shared package/definitions: state encoding (IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10), the default WIDTH/SLAVES values already in the definitions file, and the onehot-check function.
- One sub-module: apb_slave_mux. It selects the Prdata, Pready and Pslverr of the latched one-hot sel (combinational AND-OR). It is reused by the future multi-port bridge.

Test Plan:
1. Write, 0 wait states: req addr 0x8000_0010, wdata 0xDEAD_BEEF, sel 3'b001, Pready[0] = 1 -> SETUP then ACCESS with Penable high 1 cycle; rsp_valid 3 cycles after accept, err = 0, rdata = 0.
2. Read, 2 wait states: sel 3'b100, Pready[2] low 2 ACCESS cycles, Prdata slice 2 = 0x1234_5678 -> Paddr stable for 4 cycles; rsp_rdata = 0x1234_5678, err = 0.
3. Slave error: read sel 3'b010, Pslverr[1] = 1 with Pready[1] = 1 -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
4. Timeout: TIMEOUT = 4, Pready held 0 -> exactly 4 ACCESS cycles, then Pselx = 0, rsp_err = 1, rsp_timeout = 1; next request accepted normally.
5. Illegal select: req_sel 3'b011 and then 3'b000 -> no Pselx activity; rsp_err = 1 one cycle after each accept.
6. Reset mid-ACCESS: Hresetn low during a wait state -> next edge Pselx = 0, Penable = 0, rsp_valid = 0, req_ready = 1 after release.
